serial_subtractor_ctrl: RTL
===========================

SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand set offered.
REQ-005 in_ready  output  1  controller can accept operands.
REQ-006 a  input  WIDTH  minuend, unsigned.
REQ-007 b  input  WIDTH  subtrahend, unsigned.
REQ-008 bin  input  1  borrow-in.
REQ-009 abort  input  1  synchronous cancel of the current operation.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH.
REQ-013 bout  output  1  final borrow-out.
REQ-014 busy  output  1  high in RUN or DONE.

Function
REQ-015 The block SHALL compute the result bit-serially, LSB first, using exactly one 1-bit full-subtract cell (diff = a^b^bin; bout = (~a&b)|(~(a^b)&bin)) per clock, with the borrow held in a register between bits.
REQ-016 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-017 in_ready SHALL equal (state==IDLE) and not rst; it is combinational from state.
REQ-018 Accept: in_valid & in_ready at an edge -> latch a, b into shift registers, load borrow register with bin, clear bit counter, clear result register, go to RUN.
REQ-019 RUN, each edge: process LSB of a/b shift registers with borrow register; shift result bit into result MSB (result shifts right); shift a/b right; update borrow register; increment counter.
REQ-020 RUN -> DONE on the edge where counter == WIDTH-1 (the WIDTH-th processed bit).
REQ-021 Latency: accept at edge 0 -> out_valid high after edge WIDTH; throughput at most one operation per WIDTH+2 cycles with out_ready held high.
REQ-022 DONE: out_valid=1; diff and bout SHALL hold stable until handshake; out_valid & out_ready at an edge -> IDLE.
REQ-023 out_valid SHALL be registered (state==DONE); diff/bout registered, never glitching while out_valid is high.
REQ-024 in_valid SHALL be ignored in RUN and DONE; a, b, bin changing after accept SHALL not affect the result.
REQ-025 abort high at an edge in RUN or DONE -> IDLE, out_valid 0, diff 0, bout 0; abort in IDLE SHALL be ignored and has priority over an accept in the same cycle (no accept).
REQ-026 abort and out_ready asserted together in DONE -> treated as abort (result discarded, same next state IDLE).
REQ-027 Arithmetic: bout SHALL be 1 iff a < b + bin (unsigned, WIDTH+1-bit compare); diff wraps modulo 2^WIDTH.

Reset
REQ-028 rst assertion SHALL immediately (no clock) force state IDLE, out_valid 0, diff 0, bout 0, busy 0, counter 0, borrow register 0.
REQ-029 rst asserted mid-RUN or in DONE SHALL discard the operation; no out_valid pulse after deassertion.
REQ-030 First accept is possible at the first rising edge after rst deasserts.

Verification (WIDTH=8)
REQ-031 a=0x05, b=0x03, bin=0 accepted at edge 0 -> out_valid high after edge 8, diff=0x02, bout=0.
REQ-032 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1; a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0.
REQ-033 Backpressure: out_ready low 5 cycles in DONE with in_valid held high and a/b toggling -> out_valid, diff, bout stable; in_ready 0; no second accept until after the out handshake.
REQ-034 abort on the 3rd RUN cycle -> next cycle IDLE, in_ready 1, no out_valid; a following a=0x10, b=0x01, bin=0 yields diff=0x0F, bout=0.
REQ-035 Async rst pulse mid-RUN (between edges) -> outputs zero before next edge; no result emitted.
REQ-036 10k random (a, b, bin) with random out_ready stalls -> every diff/bout matches the REQ-027 model; operation count in equals count out.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// -----------------------------------------------------------------------------
// serial_subtractor_ctrl
//
// Bit-serial unsigned subtractor with a valid/ready operand port and a
// valid/ready result port. One full-subtract cell is reused every clock,
// working LSB first. The borrow ripples between bits through a register.
// A WIDTH-bit operation takes WIDTH cycles in RUN, followed by DONE. DONE
// holds the result until the consumer takes it.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : operand set (a, b, bin) offered
//   in_ready   : controller idle and able to accept operands
//   a          : minuend, unsigned, WIDTH bits
//   b          : subtrahend, unsigned, WIDTH bits
//   bin        : borrow-in
//   abort      : synchronous cancel of the operation in RUN or DONE
//   out_valid  : result available (registered)
//   out_ready  : consumer accepts the result
//   diff       : (a - b - bin) mod 2^WIDTH (registered)
//   bout       : final borrow-out, 1 iff a < b + bin
//   busy       : high while in RUN or DONE
// -----------------------------------------------------------------------------
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Operand shift registers and the partial result. These carry no
    // reset because every operation starts by loading them on accept.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;

    // Control state and registered outputs.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             out_valid_q, out_valid_d;

    // 1-bit full-subtract cell
    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    logic cell_diff;
    logic cell_bout;
    logic accept;
    logic last_bit;
    logic [WIDTH-1:0] res_shifted;

    assign cell_diff   = fs_diff(a_q[0], b_q[0], borrow_q);
    assign cell_bout   = fs_borrow(a_q[0], b_q[0], borrow_q);
    assign res_shifted = {cell_diff, res_q[WIDTH-1:1]};
    assign last_bit    = (cnt_q == LAST_BIT);

    // in_ready drops as soon as rst rises, without waiting for the clock.
    assign in_ready = (state_q == IDLE) && !rst;
    // abort beats a same-cycle accept.
    assign accept   = in_valid && in_ready && !abort;

    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // abort takes precedence over a simultaneous out handshake;
                // either way the next state is IDLE.
                if (abort || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        borrow_d    = borrow_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    res_d    = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_d       = '0;
                    borrow_d    = 1'b0;
                    diff_d      = '0;
                    bout_d      = 1'b0;
                    out_valid_d = 1'b0;
                end else begin
                    a_d      = a_q >> 1;
                    b_d      = b_q >> 1;
                    res_d    = res_shifted;
                    borrow_d = cell_bout;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        // The final bit completes the result. Publish it to
                        // the output registers in the same edge so that
                        // diff/bout are already stable when out_valid rises.
                        cnt_d       = '0;
                        diff_d      = res_shifted;
                        bout_d      = cell_bout;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    diff_d      = '0;
                    bout_d      = 1'b0;
                    out_valid_d = 1'b0;
                    borrow_d    = 1'b0;
                end else if (out_ready) begin
                    // diff/bout keep the last result after the handshake.
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                cnt_d       = '0;
                borrow_d    = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Control and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            borrow_q    <= borrow_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Operand and partial-result shift registers
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        res_q <= res_d;
    end

endmodule
